// File: rtl/mem_arbiter.sv
// Shared single-port memory arbitrated among NUM_PORTS requesters; grant is combinational and the response is registered one cycle after acceptance.
// Only the winner sees ready, so the others stall. Round-robin by default; defining MEM_ARBITER_FIXED_PRIO_EN selects lowest-index-wins priority.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 'h10000
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_valid_i,
  output logic [NUM_PORTS-1:0]              req_ready_o,
  input  logic [NUM_PORTS-1:0]              req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic [NUM_PORTS-1:0]              rsp_valid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [NUM_PORTS-1:0]              rsp_err_o
);
  localparam int STRB  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(STRB);
  localparam int WORDS = MEM_SIZE / STRB;
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] prio_q, prio_d;

  // prio and the scan offset are both below NUM_PORTS, so one subtraction wraps.
  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= NUM_PORTS) ? PW'(v - NUM_PORTS) : PW'(v);
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[wrap(int'(prio_q) + i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap(int'(prio_q) + i);
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_vld) begin
      prio_d = wrap(int'(gnt_idx) + 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  always_comb begin
    req_ready_o = '0;
    if (gnt_vld) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB-1:0]       sel_wstrb;
  logic                  in_range;
  logic [IDXW-1:0]       word_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr;

  assign sel_we      = req_we_i[gnt_idx];
  assign sel_addr    = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata   = req_wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_wstrb   = req_wstrb_i[int'(gnt_idx)*STRB +: STRB];
  assign in_range    = 64'(sel_addr) < 64'(MEM_SIZE);
  assign word_idx    = sel_addr[OFF +: IDXW];
  assign rd_word     = in_range ? mem[word_idx] : '0;
  assign unused_addr = ^sel_addr;

  // Contents are not reset; writes are blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_ni && gnt_vld && sel_we && in_range) begin
      for (int b = 0; b < STRB; b++) begin
        if (sel_wstrb[b]) begin
          mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  logic [NUM_PORTS-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [NUM_PORTS-1:0]            rsp_err_q, rsp_err_d;

  // Data and error of ports not granted this cycle hold their last response.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (gnt_vld) begin
      rsp_valid_d[gnt_idx] = 1'b1;
      rsp_err_d[gnt_idx]   = ~in_range;
      rsp_rdata_d[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] = (!sel_we && in_range) ? rd_word : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Unified single-port memory with a parametrised number of requester ports. Each port uses a valid/ready request channel and a one-cycle registered response. A round-robin arbiter grants one request per cycle, so several managers can share one SRAM array, for example a core's instruction and data buses plus a debug or DMA port. It replaces the separate fixed-latency instruction and data SRAMs at the SoC top level when a shared memory map is required.

## Interface
Parameters:
- NUM_PORTS, 2, number of requester ports (1..8)
- ADDR_WIDTH, 32, request byte-address width
- DATA_WIDTH, 32, data width; power of two, at least 8
- MEM_SIZE, 'h10000, memory size in bytes; multiple of DATA_WIDTH/8

Ports (STRB = DATA_WIDTH/8):
- clk_i  in  1  clock; reset is asynchronous and active-low
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_PORTS  per-port request valid
- req_ready_o  out  NUM_PORTS  per-port grant; a request is accepted when valid & ready
- req_we_i  in  NUM_PORTS  1 = write, 0 = read
- req_addr_i  in  NUM_PORTS x ADDR_WIDTH  byte address
- req_wdata_i  in  NUM_PORTS x DATA_WIDTH  write data
- req_wstrb_i  in  NUM_PORTS x STRB  byte enables for writes
- rsp_valid_o  out  NUM_PORTS  one-cycle response pulse
- rsp_rdata_o  out  NUM_PORTS x DATA_WIDTH  read data
- rsp_err_o  out  NUM_PORTS  address out of range; qualified by rsp_valid_o

## Operation
- Each cycle the arbiter scans req_valid_i starting at the priority pointer `prio` and moving upward modulo NUM_PORTS. The first valid port wins.
- req_ready_o is one-hot or zero and is asserted combinationally for the winner only. Ready depends on valid.
- A requester holds valid, we, addr, wdata and wstrb stable until it sees ready. Valid is not withdrawn before acceptance.
- After an accepted request from port k, `prio` becomes (k+1) mod NUM_PORTS. With no accepted request, `prio` is unchanged.
- Address decode:
  - Word index = addr[ADDR_WIDTH-1:log2(STRB)]. Low bits are ignored.
  - An address is in range when addr < MEM_SIZE.
- Accepted write, in range: each byte with a set wstrb bit is updated at the clock edge.
- Accepted read, in range: the addressed word is read.
- Out-of-range request: memory is untouched and the response has err = 1 and rdata = 0.
- Response, the cycle after acceptance:
  - rsp_valid_o[k] = 1 and rsp_err_o[k] reflects the range check.
  - For reads, rsp_rdata_o[k] holds the word. For writes, it is 0.
  - All other ports have rsp_valid_o = 0.
- rsp_rdata_o and rsp_err_o of a port hold their last values until that port's next response.
- A read accepted the cycle after a write to the same word returns the written data. No bypass is needed because there is one grant per cycle.
- NUM_PORTS = 1: the arbiter degenerates so that ready = valid.

## Timing
- Reset values: prio = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0. req_ready_o follows valid combinationally even during reset.
- Memory contents are not reset.
- Reset asserted mid-operation:
  - A response pending for the next edge is dropped, and rsp_valid_o goes to 0 asynchronously.
  - Any write that occurs at an edge while rst_ni is low is suppressed.
- Latency: request accepted at edge n, response visible after edge n+1, i.e. one cycle.
- Throughput: one accepted request per cycle across all ports, with no bubbles.
- Back-to-back requests from one port: each one is accepted only when that port wins arbitration.
- Worst-case wait for a continuously valid port in round-robin mode: NUM_PORTS-1 cycles.

## Configuration
- MEM_ARBITER_FIXED_PRIO_EN defined:
  - Fixed priority, where the lowest-index valid port always wins.
  - `prio` is not implemented.
  - Higher ports may starve.
- Not defined: round-robin as described above.

## Test plan
- Reset, then a single read: port 0 reads 0x0 after reset. Required: ready0 = 1 in the same cycle; rsp_valid_o = 2'b01 one cycle later; rsp_rdata_o[0] = 0 (mem preloaded 0); err = 0.
- Byte-strobe write then read: port 1 writes 0xAABBCCDD to 0x100 with wstrb 4'b1111, then 0x11223344 to 0x100 with wstrb 4'b0101. A port 0 read of 0x100 must return 0xAA22CC44.
- Round-robin contention: both ports hold valid for 4 cycles. Required grant sequence 0,1,0,1 and responses alternate ports one cycle behind. With MEM_ARBITER_FIXED_PRIO_EN the sequence is 0,0,0,0.
- Out of range: a write of 0xFFFFFFFF to address MEM_SIZE = 0x10000, then a read of 0x10004. Both responses have err = 1 and rdata = 0. A read of 0x0 afterwards is unchanged.
- Reset mid-operation: assert rst_ni low in the cycle after a read is accepted. Required: rsp_valid_o = 0 immediately; after release, prio = 0, so port 0 wins a simultaneous request.
- NUM_PORTS = 4, all four valid: grants 0,1,2,3,0. If only port 2 stays valid after the grant to 1, port 2 is granted in the next cycle.
